// File: rtl/picorv32_mem_arbiter.sv
// rtl/picorv32_mem_arbiter.sv - shares one native memory port among several PicoRV32 cores
// Round-robin or fixed-priority grant, locked transfer, registered responses, optional watchdog.
module picorv32_mem_arbiter #(
  parameter int          NUM_CORES      = 6,
  parameter int          PRIORITY_MODE  = 0,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF,
  localparam int         GW             = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CORES-1:0]    cyc,
  input  logic [32*NUM_CORES-1:0] adr,
  input  logic [32*NUM_CORES-1:0] dat,
  input  logic [4*NUM_CORES-1:0]  sel,
  output logic [32*NUM_CORES-1:0] rdt,
  output logic [NUM_CORES-1:0]    ack,
  output logic [NUM_CORES-1:0]    err,
  input  logic                    err_clr,
  output logic                    m_valid,
  output logic [31:0]             m_addr,
  output logic [31:0]             m_wdata,
  output logic [3:0]              m_wstrb,
  input  logic [31:0]             m_rdata,
  input  logic                    m_ready,
  output logic [GW-1:0]           grant_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] win;
  logic [GW-1:0] cidx;
  logic [31:0]   wdog;
  logic          timeout_hit;
  int            cand;

  // Scan from the highest offset down so the last hit is the nearest candidate.
  always_comb begin
    win  = '0;
    cand = 0;
    cidx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      cand = (PRIORITY_MODE != 0) ? k : int'(rr_ptr) + k;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      cidx = GW'(cand);
      if (cyc[cidx]) win = cidx;
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wdog == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      m_valid  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
      ack      <= '0;
      rdt      <= '0;
      err      <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      wdog     <= '0;
    end else begin
      ack <= '0;
      if (err_clr) err <= '0;
      case (state)
        IDLE: begin
          if (|cyc) begin
            m_valid  <= 1'b1;
            m_addr   <= adr[{win, 5'd0} +: 32];
            m_wdata  <= dat[{win, 5'd0} +: 32];
            m_wstrb  <= sel[{win, 2'd0} +: 4];
            grant_id <= win;
            wdog     <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // A real completion takes precedence over an abort on the same edge.
          if (m_ready || timeout_hit) begin
            m_valid                  <= 1'b0;
            ack[grant_id]            <= 1'b1;
            rdt[{grant_id, 5'd0} +: 32] <= m_ready ? m_rdata : ERR_DATA;
            if (!m_ready) err[grant_id] <= 1'b1;
            state                    <= RESP;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        RESP: begin
          // cyc is deliberately ignored here while the served core drops its request.
          rr_ptr <= (grant_id == GW'(NUM_CORES - 1)) ? '0 : grant_id + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb/tb_picorv32_mem_arbiter.sv - directed and randomized checks of picorv32_mem_arbiter
module tb_picorv32_mem_arbiter;

  localparam int          N    = 6;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn, err_clr, m_ready, m_ready_fp;
  logic [N-1:0]    cyc, cyc_fp;
  logic [32*N-1:0] adr, dat;
  logic [4*N-1:0]  sel;
  logic [31:0]     m_rdata;

  logic [32*N-1:0] rdt, rdt_fp;
  logic [N-1:0]    ack, err, ack_fp, err_fp;
  logic            m_valid, m_valid_fp;
  logic [31:0]     m_addr, m_wdata, m_addr_fp, m_wdata_fp;
  logic [3:0]      m_wstrb, m_wstrb_fp;
  logic [2:0]      grant_id, grant_fp;

  picorv32_mem_arbiter #(.NUM_CORES(N), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(TO)) u_rr (
    .clk(clk), .resetn(resetn), .cyc(cyc), .adr(adr), .dat(dat), .sel(sel),
    .rdt(rdt), .ack(ack), .err(err), .err_clr(err_clr),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .grant_id(grant_id)
  );

  picorv32_mem_arbiter #(.NUM_CORES(N), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)) u_fp (
    .clk(clk), .resetn(resetn), .cyc(cyc_fp), .adr(adr), .dat(dat), .sel(sel),
    .rdt(rdt_fp), .ack(ack_fp), .err(err_fp), .err_clr(err_clr),
    .m_valid(m_valid_fp), .m_addr(m_addr_fp), .m_wdata(m_wdata_fp), .m_wstrb(m_wstrb_fp),
    .m_rdata(m_rdata), .m_ready(m_ready_fp), .grant_id(grant_fp)
  );

  int          checks = 0;
  int          errors = 0;
  int          owner, busy_cyc, dly, force_dly, gap, ptr;
  logic [31:0] exp_rdt [N];
  logic [N-1:0] exp_err;
  int          ack_cnt [N];
  int          grants[$];
  bit          rand_rd;

  task automatic chk(input string tag, input logic [32*N-1:0] obs, input logic [32*N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int start);
    for (int k = 0; k < N; k++)
      if (req[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  // One clock of the transaction-level model: who should own the bus, when its ack lands.
  task automatic step();
    logic [N-1:0]    exp_ack;
    logic [32*N-1:0] exp_vec;
    int              w;
    @(posedge clk); #1;
    exp_ack = '0;
    if (err_clr) exp_err = '0;
    if (owner >= 0) begin
      if (m_ready) begin
        exp_ack[owner] = 1'b1;
        exp_rdt[owner] = m_rdata;
      end else begin
        busy_cyc++;
        if (busy_cyc == TO) begin
          exp_ack[owner] = 1'b1;
          exp_rdt[owner] = ERRD;
          exp_err[owner] = 1'b1;
        end
      end
      if (exp_ack != '0) begin
        ptr = (owner + 1) % N;
        cyc[owner] = 1'b0;
        owner = -1;
        gap = 1;
        chk("valid_done", m_valid, 0);
      end else begin
        chk("valid_busy", m_valid, 1);
      end
    end else if (gap > 0) begin
      gap--;
      chk("valid_resp", m_valid, 0);
    end else if (cyc != '0) begin
      w = rr_pick(cyc, ptr);
      chk("valid_grant", m_valid, 1);
      chk("grant_id", grant_id, w);
      chk("m_addr", m_addr, adr[32*w +: 32]);
      chk("m_wdata", m_wdata, dat[32*w +: 32]);
      chk("m_wstrb", m_wstrb, sel[4*w +: 4]);
      owner = w;
      busy_cyc = 0;
      grants.push_back(w);
      dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 10));
    end else begin
      chk("valid_idle", m_valid, 0);
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i]) ack_cnt[i]++;
      exp_vec[32*i +: 32] = exp_rdt[i];
    end
    chk("ack", ack, exp_ack);
    chk("err", err, exp_err);
    chk("rdt", rdt, exp_vec);
    err_clr = 1'b0;
    m_ready = (owner >= 0) && (busy_cyc == dly);
    if (rand_rd) m_rdata = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit observed=expired expected=finished");
    $fatal(1);
  end

  initial begin
    int exp_order [4];
    int fp_acks, fp_other, guard;
    exp_order = '{0, 2, 5, 0};
    resetn = 1'b0; err_clr = 1'b0; m_ready = 1'b0; m_ready_fp = 1'b0;
    cyc = '0; cyc_fp = '0; adr = '0; dat = '0; sel = '0; m_rdata = '0;
    owner = -1; busy_cyc = 0; dly = 0; force_dly = -1; gap = 0; ptr = 0;
    exp_err = '0; rand_rd = 1'b1;
    for (int i = 0; i < N; i++) begin exp_rdt[i] = '0; ack_cnt[i] = 0; end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_wstrb", m_wstrb, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdt", rdt, 0);
    chk("rst_grant", grant_id, 0);
    resetn = 1'b1;

    // round-robin order from pointer 0
    force_dly = 0;
    for (int i = 0; i < N; i++) begin adr[32*i +: 32] = $urandom; dat[32*i +: 32] = $urandom; end
    cyc = 6'b100101;
    repeat (9) step();
    cyc[0] = 1'b1;
    repeat (3) step();
    chk("rr_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < grants.size()) ? grants[i] : -1, exp_order[i]);
    chk("rr_ack0", ack_cnt[0], 2);
    chk("rr_ack2", ack_cnt[2], 1);
    chk("rr_ack5", ack_cnt[5], 1);

    // single read, zero-wait downstream
    rand_rd = 1'b0; m_rdata = 32'h1234_5678;
    adr[31:0] = 32'h0000_0100; sel[3:0] = 4'h0; cyc = 6'b000001;
    step();
    chk("rd_wstrb", m_wstrb, 0);
    chk("rd_ack_early", ack, 0);
    step();
    chk("rd_ack_lat2", ack, 6'b000001);
    chk("rd_data", rdt[31:0], 32'h1234_5678);
    step();
    chk("rd_ack_once", ack, 0);

    // partial write from core 3
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    adr[96 +: 32] = 32'h40; dat[96 +: 32] = 32'hAABB_CCDD; sel[12 +: 4] = 4'b0011;
    force_dly = 2; cyc = 6'b001000;
    step();
    chk("wr_wstrb", m_wstrb, 4'b0011);
    chk("wr_wdata", m_wdata, 32'hAABB_CCDD);
    chk("wr_addr", m_addr, 32'h40);
    repeat (5) step();
    chk("wr_ack_count", ack_cnt[3], 1);

    // watchdog abort, error clear, then completion on the last allowed cycle
    force_dly = 100; sel[4 +: 4] = 4'h0; cyc = 6'b000010;
    step();
    repeat (7) step();
    chk("to_no_ack", ack, 0);
    step();
    chk("to_ack", ack, 6'b000010);
    chk("to_rdt", rdt[32 +: 32], ERRD);
    chk("to_err", err, 6'b000010);
    err_clr = 1'b1;
    step();
    chk("to_err_clr", err, 0);
    m_rdata = 32'h0BAD_F00D; force_dly = 7; cyc[1] = 1'b1;
    step();
    repeat (7) step();
    chk("edge_no_ack", ack, 0);
    step();
    chk("edge_ack", ack, 6'b000010);
    chk("edge_rdt", rdt[32 +: 32], 32'h0BAD_F00D);
    chk("edge_err", err, 0);
    step();

    // fixed priority: core 0 keeps requesting and starves cores 2 and 5
    fp_acks = 0; fp_other = 0;
    m_rdata = 32'h5A5A_0001; m_ready_fp = 1'b1; cyc_fp = 6'b100101;
    repeat (12) begin
      @(posedge clk); #1;
      if (ack_fp[0]) fp_acks++;
      if (ack_fp[5:1] != '0) fp_other++;
      if (m_valid_fp) begin
        chk("fp_grant", grant_fp, 0);
        chk("fp_addr", m_addr_fp, adr[31:0]);
        chk("fp_wdata", m_wdata_fp, dat[31:0]);
        chk("fp_wstrb", m_wstrb_fp, sel[3:0]);
      end
    end
    chk("fp_core0_acks", fp_acks, 4);
    chk("fp_others_wait", fp_other, 0);
    chk("fp_rdt", rdt_fp[31:0], 32'h5A5A_0001);
    chk("fp_err", err_fp, 0);
    cyc_fp = '0; m_ready_fp = 1'b0;

    // randomized traffic
    rand_rd = 1'b1; force_dly = -1;
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        if (!cyc[i] && i != owner && $urandom_range(0, 3) == 0) begin
          adr[32*i +: 32] = $urandom;
          dat[32*i +: 32] = $urandom;
          sel[4*i +: 4]   = 4'($urandom);
          cyc[i]          = 1'b1;
        end
      end
      if ($urandom_range(0, 15) == 0) err_clr = 1'b1;
      step();
    end
    guard = 0;
    while ((cyc != '0 || owner >= 0 || gap > 0) && guard < 500) begin
      step();
      guard++;
    end
    chk("drain", guard < 500, 1);

    // reset in the middle of a transfer
    force_dly = 0; cyc = 6'b001000;
    repeat (3) step();
    force_dly = 100; cyc = 6'b000100;
    repeat (9) step();
    step();
    cyc = 6'b010000;
    repeat (3) step();
    resetn = 1'b0;
    #1;
    chk("rst_busy_valid", m_valid, 0);
    chk("rst_busy_ack", ack, 0);
    chk("rst_busy_err", err, 0);
    chk("rst_busy_rdt", rdt, 0);
    owner = -1; gap = 0; ptr = 0; exp_err = '0; cyc = '0; m_ready = 1'b0;
    for (int i = 0; i < N; i++) exp_rdt[i] = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    grants.delete();
    force_dly = 0; cyc = 6'b010100;
    repeat (6) step();
    chk("post_rst_first", (grants.size() > 0) ? grants[0] : -1, 2);
    chk("post_rst_second", (grants.size() > 1) ? grants[1] : -1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
